// File: rtl/imm_gen_stage.sv
// imm_gen_stage: RISC-V immediate extraction/extension stage with a
// two-entry (output + skid) elastic buffer. in_ready is a pure register
// (skid empty), so there is no combinational out_ready -> in_ready path.
// Optional build macro: IMM_GEN_ZIMM_EN enables op 110 (CSR zimm, din[12:8]
// zero-extended). Without it, op 110 reports out_err like op 111.
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [24:0]      in_din,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  typedef struct packed {
    logic [XLEN-1:0]  ext;
    logic [TAG_W-1:0] tag;
    logic             err;
  } ent_t;

  ent_t nxt, obuf, sbuf;
  logic o_vld, s_vld;
  logic sgn;
  logic accept, o_stall;

  assign sgn     = in_din[24];
  assign accept  = in_valid & ~s_vld;
  assign o_stall = o_vld & ~out_ready;

  // Decode the immediate format; din holds instruction bits [31:7], so the
  // instruction's sign bit 31 is din[24]. Sign fill first, then low bits.
  always_comb begin
    nxt     = '0;
    nxt.tag = in_tag;
    case (in_op)
      3'b000: begin
        nxt.ext       = {XLEN{sgn}};
        nxt.ext[11:0] = in_din[24:13];
      end
      3'b001: begin
        nxt.ext[4:0] = in_din[17:13];
        if (XLEN == 64) nxt.ext[5] = in_din[18];
      end
      3'b010: begin
        nxt.ext       = {XLEN{sgn}};
        nxt.ext[11:0] = {in_din[24:18], in_din[4:0]};
      end
      3'b011: begin
        // bit 31 of the U immediate is the sign, so XLEN=64 fills 63:32
        nxt.ext        = {XLEN{sgn}};
        nxt.ext[31:0]  = {in_din[24:5], 12'b0};
      end
      3'b100: begin
        nxt.ext       = {XLEN{sgn}};
        nxt.ext[11:0] = {in_din[0], in_din[23:18], in_din[4:1], 1'b0};
      end
      3'b101: begin
        nxt.ext       = {XLEN{sgn}};
        nxt.ext[19:0] = {in_din[12:5], in_din[13], in_din[23:14], 1'b0};
      end
`ifdef IMM_GEN_ZIMM_EN
      3'b110: nxt.ext[4:0] = in_din[12:8];
`else
      3'b110: nxt.err = 1'b1;
`endif
      default: nxt.err = 1'b1;
    endcase
  end

  // Output/skid buffer: new data goes to the output register unless the
  // output is stalled, in which case it parks in the skid; a draining output
  // refills from the skid first. Flush drops both valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vld <= 1'b0;
      s_vld <= 1'b0;
      obuf  <= '0;
      sbuf  <= '0;
    end else if (flush) begin
      o_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (o_stall) begin
      if (accept) begin
        s_vld <= 1'b1;
        sbuf  <= nxt;
      end
    end else if (s_vld) begin
      // in_ready is low while the skid is full, so no accept can collide
      obuf  <= sbuf;
      o_vld <= 1'b1;
      s_vld <= 1'b0;
    end else if (accept) begin
      obuf  <= nxt;
      o_vld <= 1'b1;
    end else begin
      o_vld <= 1'b0;
    end
  end

  assign in_ready  = ~s_vld;
  assign out_valid = o_vld;
  assign out_ext   = obuf.ext;
  assign out_tag   = obuf.tag;
  assign out_err   = obuf.err;

endmodule
